// File: rtl/updi_pkg.sv
// -----------------------------------------------------------------------------
// updi_pkg
// Shared UPDI definitions: UART frame constants, the 12-bit frame type, the
// frame-writer state encoding and the frame/parity helper functions. The frame
// builder is shared with the receive-side decoder.
// -----------------------------------------------------------------------------
package updi_pkg;

  localparam logic       UPDI_START = 1'b0;
  localparam logic [1:0] UPDI_STOP  = 2'b11;
  localparam int         FRAME_W    = 12;

  // Line order: bit 0 is transmitted first.
  typedef logic [FRAME_W-1:0] updi_frame_t;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    WRITE   = 2'd1,
    TX_REQ  = 2'd2,
    TX_WAIT = 2'd3
  } fw_state_t;

  // Parity bit over the data byte; odd = 1'b1 flips even parity to odd.
  function automatic logic updi_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  // {stop[1:0], parity, data[7:0] LSB-first, start}
  function automatic updi_frame_t updi_make_frame(input logic [7:0] data, input logic odd);
    return {UPDI_STOP, updi_parity(data, odd), data, UPDI_START};
  endfunction

endpackage

// File: rtl/updi_frame_writer.sv
// -----------------------------------------------------------------------------
// updi_frame_writer
// Takes command bytes from CG_FSM, wraps each into a 12-bit UPDI UART frame and
// stores the frames at consecutive BUFF_MEM addresses. At the end of a command
// (i_last) or when the buffer is full, hands the memory port to PHY, pulses
// o_ten with the frame count on o_len, and waits for i_tend before accepting
// further bytes.
//
// Ports:
//   i_clk, i_rstn            clock, synchronous active-low reset
//   i_data/i_valid/i_last    byte stream from CG_FSM (handshake with o_ready)
//   o_ready                  byte can be accepted this cycle
//   o_csb0/o_web0            BUFF_MEM chip select / write enable, active low
//   o_addr0/o_din0           BUFF_MEM address and frame word
//   o_mem_own                1 = this block drives BUFF_MEM, 0 = PHY does
//   o_ten/o_len              transmit-enable pulse and frame count to PHY
//   i_tend                   end-of-transmission pulse from PHY
//   o_busy                   high whenever not in FILL
// -----------------------------------------------------------------------------
module updi_frame_writer
  import updi_pkg::*;
#(
  parameter int ADDR_W     = 7,
  parameter int DEPTH      = 128,
  parameter int PARITY_ODD = 0
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [7:0]        i_data,
  input  logic              i_valid,
  input  logic              i_last,
  output logic              o_ready,
  output logic              o_csb0,
  output logic              o_web0,
  output logic [ADDR_W-1:0] o_addr0,
  output logic [11:0]       o_din0,
  output logic              o_mem_own,
  output logic              o_ten,
  output logic [ADDR_W:0]   o_len,
  input  logic              i_tend,
  output logic              o_busy
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic            ODD_C   = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  fw_state_t         r_state;
  fw_state_t         w_state_nxt;

  // Write pointer is one bit wider than the address so a full buffer
  // (DEPTH == 2**ADDR_W) can be expressed as a count.
  logic [ADDR_W:0]   r_wptr;
  logic              r_last_q;
  logic              r_ready;
  logic              r_csb0;
  logic              r_web0;
  logic [ADDR_W-1:0] r_addr0;
  updi_frame_t       r_din0;
  logic              r_mem_own;
  logic              r_ten;
  logic [ADDR_W:0]   r_len;
  logic              r_busy;

  logic [ADDR_W:0]   w_wptr_nxt;
  logic              w_last_q_nxt;
  logic              w_ready_nxt;
  logic              w_csb0_nxt;
  logic              w_web0_nxt;
  logic [ADDR_W-1:0] w_addr0_nxt;
  updi_frame_t       w_din0_nxt;
  logic              w_mem_own_nxt;
  logic              w_ten_nxt;
  logic [ADDR_W:0]   w_len_nxt;
  logic              w_busy_nxt;

  logic              w_accept;
  logic [ADDR_W:0]   w_wptr_inc;
  logic              w_flush;

  assign w_accept   = (r_state == FILL) && r_ready && i_valid;
  assign w_wptr_inc = r_wptr + {{ADDR_W{1'b0}}, 1'b1};
  // A full buffer forces a flush even without i_last; both together flush once.
  assign w_flush    = r_last_q || (w_wptr_inc == DEPTH_C);

  // State register and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state   <= FILL;
      r_wptr    <= {(ADDR_W + 1){1'b0}};
      r_last_q  <= 1'b0;
      r_ready   <= 1'b0;
      r_csb0    <= 1'b1;
      r_web0    <= 1'b1;
      r_addr0   <= {ADDR_W{1'b0}};
      r_din0    <= {FRAME_W{1'b0}};
      r_mem_own <= 1'b1;
      r_ten     <= 1'b0;
      r_len     <= {(ADDR_W + 1){1'b0}};
      r_busy    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_wptr    <= w_wptr_nxt;
      r_last_q  <= w_last_q_nxt;
      r_ready   <= w_ready_nxt;
      r_csb0    <= w_csb0_nxt;
      r_web0    <= w_web0_nxt;
      r_addr0   <= w_addr0_nxt;
      r_din0    <= w_din0_nxt;
      r_mem_own <= w_mem_own_nxt;
      r_ten     <= w_ten_nxt;
      r_len     <= w_len_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL: begin
        if (w_accept) begin
          w_state_nxt = WRITE;
        end else begin
          w_state_nxt = FILL;
        end
      end
      WRITE: begin
        if (w_flush) begin
          w_state_nxt = TX_REQ;
        end else begin
          w_state_nxt = FILL;
        end
      end
      TX_REQ: begin
        w_state_nxt = TX_WAIT;
      end
      TX_WAIT: begin
        if (i_tend) begin
          w_state_nxt = FILL;
        end else begin
          w_state_nxt = TX_WAIT;
        end
      end
      default: begin
        w_state_nxt = FILL;
      end
    endcase
  end

  // Next values of the registered outputs and datapath registers.
  always_comb begin
    w_wptr_nxt    = r_wptr;
    w_last_q_nxt  = r_last_q;
    w_ready_nxt   = 1'b0;
    w_csb0_nxt    = 1'b1;
    w_web0_nxt    = 1'b1;
    w_addr0_nxt   = r_addr0;
    w_din0_nxt    = r_din0;
    w_mem_own_nxt = r_mem_own;
    w_ten_nxt     = 1'b0;
    w_len_nxt     = r_len;
    w_busy_nxt    = (w_state_nxt != FILL);
    case (r_state)
      FILL: begin
        if (w_accept) begin
          w_din0_nxt   = updi_make_frame(i_data, ODD_C);
          w_addr0_nxt  = r_wptr[ADDR_W-1:0];
          w_csb0_nxt   = 1'b0;
          w_web0_nxt   = 1'b0;
          w_last_q_nxt = i_last;
          w_ready_nxt  = 1'b0;
        end else begin
          // Also covers the first cycle after reset release.
          w_ready_nxt  = 1'b1;
        end
      end
      WRITE: begin
        w_wptr_nxt = w_wptr_inc;
        if (w_flush) begin
          w_len_nxt   = w_wptr_inc;
          w_ready_nxt = 1'b0;
        end else begin
          w_ready_nxt = 1'b1;
        end
      end
      TX_REQ: begin
        // Memory port goes to PHY together with the enable pulse; o_csb0 is
        // already high here, so it is never low while PHY owns the port.
        w_mem_own_nxt = 1'b0;
        w_ten_nxt     = 1'b1;
      end
      TX_WAIT: begin
        if (i_tend) begin
          w_wptr_nxt    = {(ADDR_W + 1){1'b0}};
          w_mem_own_nxt = 1'b1;
          w_len_nxt     = {(ADDR_W + 1){1'b0}};
          w_ready_nxt   = 1'b1;
        end else begin
          w_ready_nxt   = 1'b0;
        end
      end
      default: begin
        w_ready_nxt = 1'b0;
      end
    endcase
  end

  assign o_ready   = r_ready;
  assign o_csb0    = r_csb0;
  assign o_web0    = r_web0;
  assign o_addr0   = r_addr0;
  assign o_din0    = r_din0;
  assign o_mem_own = r_mem_own;
  assign o_ten     = r_ten;
  assign o_len     = r_len;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_updi_frame_writer.sv
// -----------------------------------------------------------------------------
// tb_updi_frame_writer
// Directed bench for updi_frame_writer: an even-parity instance carries most
// scenarios, an odd-parity instance checks the parity option. Inputs change
// 1 time unit after the rising edge; outputs are read at the same point.
// -----------------------------------------------------------------------------
module tb_updi_frame_writer;

  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rstn;
  logic [7:0]    data;
  logic          valid, last, tend;
  logic          o_ready, o_csb0, o_web0, o_mem_own, o_ten, o_busy;
  logic [AW-1:0] o_addr0;
  logic [11:0]   o_din0;
  logic [AW:0]   o_len;

  logic [7:0]    data2;
  logic          valid2, last2, tend2;
  logic          o_ready2, o_csb02, o_web02, o_mem_own2, o_ten2, o_busy2;
  logic [AW-1:0] o_addr02;
  logic [11:0]   o_din02;
  logic [AW:0]   o_len2;

  int n_chk  = 0;
  int n_pass = 0;

  logic [AW-1:0] wa_q[$];
  logic [11:0]   wd_q[$];
  int            ten_cnt  = 0;
  int            own_viol = 0;

  always #5 clk = ~clk;

  updi_frame_writer #(.ADDR_W(AW), .DEPTH(128), .PARITY_ODD(0)) u_dut (
    .i_clk(clk), .i_rstn(rstn), .i_data(data), .i_valid(valid), .i_last(last),
    .o_ready(o_ready), .o_csb0(o_csb0), .o_web0(o_web0), .o_addr0(o_addr0),
    .o_din0(o_din0), .o_mem_own(o_mem_own), .o_ten(o_ten), .o_len(o_len),
    .i_tend(tend), .o_busy(o_busy)
  );

  updi_frame_writer #(.ADDR_W(AW), .DEPTH(128), .PARITY_ODD(1)) u_dut_odd (
    .i_clk(clk), .i_rstn(rstn), .i_data(data2), .i_valid(valid2), .i_last(last2),
    .o_ready(o_ready2), .o_csb0(o_csb02), .o_web0(o_web02), .o_addr0(o_addr02),
    .o_din0(o_din02), .o_mem_own(o_mem_own2), .o_ten(o_ten2), .o_len(o_len2),
    .i_tend(tend2), .o_busy(o_busy2)
  );

  // Memory-side monitor: log writes, count o_ten pulses, flag ownership clashes.
  always @(negedge clk) begin
    if (rstn === 1'b1 && o_csb0 === 1'b0 && o_web0 === 1'b0) begin
      wa_q.push_back(o_addr0);
      wd_q.push_back(o_din0);
    end
    if (o_ten === 1'b1) ten_cnt++;
    if (o_csb0 === 1'b0 && o_mem_own === 1'b0) own_viol++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference frame: {stop=11, parity, data LSB first, start=0}.
  function automatic logic [11:0] mk_frame(input logic [7:0] d, input logic odd);
    return {2'b11, (^d) ^ odd, d, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    ten_cnt = 0;
  endtask

  // Present a byte and hold it until the handshake; stall = cycles waited.
  task automatic send(input logic [7:0] d, input logic l, output int stall);
    data  = d;
    valid = 1'b1;
    last  = l;
    stall = 0;
    while (!o_ready && stall < 1000) begin
      tick();
      stall++;
    end
    if (stall >= 1000) begin
      chk("send_timeout", 32'd1, 32'd0);
    end else begin
      tick();
      chk("ready_drop", {31'd0, o_ready}, 32'd0);
    end
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic wait_ten(output logic [AW:0] len);
    int cnt;
    cnt = 0;
    while (!o_ten && cnt < 1000) begin
      tick();
      cnt++;
    end
    chk("ten_seen", {31'd0, o_ten}, 32'd1);
    len = o_len;
  endtask

  task automatic end_tx();
    tend = 1'b1;
    tick();
    tend = 1'b0;
    chk("tend_own", {31'd0, o_mem_own}, 32'd1);
    chk("tend_len", {24'd0, o_len}, 32'd0);
    chk("tend_ready", {31'd0, o_ready}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_ready"}, {31'd0, o_ready}, 32'd0);
    chk({pfx, "_csb"},   {31'd0, o_csb0}, 32'd1);
    chk({pfx, "_web"},   {31'd0, o_web0}, 32'd1);
    chk({pfx, "_addr"},  {25'd0, o_addr0}, 32'd0);
    chk({pfx, "_din"},   {20'd0, o_din0}, 32'd0);
    chk({pfx, "_own"},   {31'd0, o_mem_own}, 32'd1);
    chk({pfx, "_ten"},   {31'd0, o_ten}, 32'd0);
    chk({pfx, "_len"},   {24'd0, o_len}, 32'd0);
    chk({pfx, "_busy"},  {31'd0, o_busy}, 32'd1);
  endtask

  initial begin
    int          st, s1, s2, err, rdy_seen, cnt;
    logic [AW:0] len;
    logic [11:0] exp_d [3];

    rstn = 1'b0; data = 8'h00; valid = 1'b0; last = 1'b0; tend = 1'b0;
    data2 = 8'h00; valid2 = 1'b0; last2 = 1'b0; tend2 = 1'b0;
    exp_d = '{12'hCAA, 12'hF00, 12'hE02};

    // Reset state, then FILL with ready one cycle after release.
    repeat (3) tick();
    chk_reset_vals("rst");
    rstn = 1'b1;
    tick();
    chk("rel_ready", {31'd0, o_ready}, 32'd1);
    chk("rel_busy",  {31'd0, o_busy}, 32'd0);

    // Odd parity instance: 0x00 -> 12'hE00 at address 0.
    data2 = 8'h00; valid2 = 1'b1; last2 = 1'b1;
    cnt = 0;
    while (!o_ready2 && cnt < 100) begin tick(); cnt++; end
    tick();
    valid2 = 1'b0; last2 = 1'b0;
    chk("odd_csb",  {31'd0, o_csb02}, 32'd0);
    chk("odd_web",  {31'd0, o_web02}, 32'd0);
    chk("odd_addr", {25'd0, o_addr02}, 32'd0);
    chk("odd_din",  {20'd0, o_din02}, 32'h0000_0E00);

    // Single SYNCH byte with i_last.
    clear_log();
    send(8'h55, 1'b1, st);
    wait_ten(len);
    chk("t1_len", {24'd0, len}, 32'd1);
    chk("t1_own", {31'd0, o_mem_own}, 32'd0);
    repeat (5) tick();
    chk("t1_ten_once", ten_cnt, 32'd1);
    chk("t1_own_hold", {31'd0, o_mem_own}, 32'd0);
    chk("t1_len_hold", {24'd0, o_len}, 32'd1);
    end_tx();
    chk("t1_nwr", wa_q.size(), 32'd1);
    chk("t1_addr", {25'd0, wa_q[0]}, 32'd0);
    chk("t1_din", {20'd0, wd_q[0]}, 32'h0000_0CAA);

    // Three-byte command; one byte accepted every other cycle.
    clear_log();
    send(8'h55, 1'b0, st);
    send(8'h80, 1'b0, s1);
    send(8'h01, 1'b1, s2);
    chk("t2_stall1", s1, 32'd1);
    chk("t2_stall2", s2, 32'd1);
    wait_ten(len);
    chk("t2_len", {24'd0, len}, 32'd3);
    end_tx();
    chk("t2_nwr", wa_q.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t2_addr%0d", i), {25'd0, wa_q[i]}, i);
      chk($sformatf("t2_din%0d", i), {20'd0, wd_q[i]}, {20'd0, exp_d[i]});
    end

    // Full buffer without i_last forces a flush of 128 frames.
    clear_log();
    for (int i = 0; i < 128; i++) send(i[7:0], 1'b0, st);
    wait_ten(len);
    chk("t3_len", {24'd0, len}, 32'd128);
    chk("t3_nwr", wa_q.size(), 32'd128);
    err = 0;
    for (int i = 0; i < 128; i++) begin
      if (wa_q[i] !== i[AW-1:0] || wd_q[i] !== mk_frame(i[7:0], 1'b0)) err++;
    end
    chk("t3_contents", err, 32'd0);
    data = 8'hA5; valid = 1'b1; last = 1'b1;
    rdy_seen = 0;
    repeat (20) begin
      tick();
      if (o_ready) rdy_seen++;
    end
    chk("t3_stalled", rdy_seen, 32'd0);
    chk("t3_nowr", wa_q.size(), 32'd128);
    end_tx();
    send(8'hA5, 1'b1, st);
    wait_ten(len);
    chk("t3_len2", {24'd0, len}, 32'd1);
    chk("t3_wrap_addr", {25'd0, wa_q[128]}, 32'd0);
    chk("t3_wrap_din", {20'd0, wd_q[128]}, {20'd0, mk_frame(8'hA5, 1'b0)});
    end_tx();

    // Stray i_tend in FILL; i_valid held during TX_WAIT.
    clear_log();
    tend = 1'b1;
    tick();
    tend = 1'b0;
    chk("t5_ready", {31'd0, o_ready}, 32'd1);
    chk("t5_busy", {31'd0, o_busy}, 32'd0);
    chk("t5_own", {31'd0, o_mem_own}, 32'd1);
    repeat (3) tick();
    chk("t5_ready2", {31'd0, o_ready}, 32'd1);
    chk("t5_nwr0", wa_q.size(), 32'd0);
    send(8'h3C, 1'b1, st);
    wait_ten(len);
    data = 8'hC3; valid = 1'b1; last = 1'b1;
    rdy_seen = 0;
    repeat (10) begin
      tick();
      if (o_ready) rdy_seen++;
    end
    chk("t5_hold_ready", rdy_seen, 32'd0);
    chk("t5_nwr1", wa_q.size(), 32'd1);
    chk("t5_ten_once", ten_cnt, 32'd1);
    end_tx();
    send(8'hC3, 1'b1, st);
    wait_ten(len);
    chk("t5_addr", {25'd0, wa_q[1]}, 32'd0);
    chk("t5_din", {20'd0, wd_q[1]}, {20'd0, mk_frame(8'hC3, 1'b0)});
    end_tx();

    // Reset while waiting on a 5-frame transmission.
    clear_log();
    for (int i = 0; i < 5; i++) send(8'h10 + i[7:0], (i == 4), st);
    wait_ten(len);
    chk("t6_len", {24'd0, len}, 32'd5);
    repeat (3) tick();
    chk("t6_len_hold", {24'd0, o_len}, 32'd5);
    rstn = 1'b0;
    tick();
    chk_reset_vals("t6_rst");
    rstn = 1'b1;
    tick();
    chk("t6_ready", {31'd0, o_ready}, 32'd1);
    clear_log();
    send(8'h77, 1'b1, st);
    wait_ten(len);
    chk("t6_len2", {24'd0, len}, 32'd1);
    chk("t6_addr", {25'd0, wa_q[0]}, 32'd0);
    end_tx();

    chk("own_clash", own_viol, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
